// File: rtl/spi_target_if.sv
// Peripheral bus bundle between the bus controller and the SPI target.
interface spi_target_if;
  logic        peripheralEnable;
  logic        peripheralBus_we;
  logic        peripheralBus_oe;
  logic        peripheralBus_busy;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataRead;
  logic [31:0] peripheralBus_dataWrite;
  logic        requestOutput;

  modport master (
    output peripheralEnable, peripheralBus_we, peripheralBus_oe,
           peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    input  peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );

  modport slave (
    input  peripheralEnable, peripheralBus_we, peripheralBus_oe,
           peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
    output peripheralBus_busy, peripheralBus_dataRead, requestOutput
  );
endinterface

// File: rtl/spi_target.sv
// SPI target: oversamples sck/cs/mosi on clk, shifts one byte per 8 sample edges,
// and exposes config/data/status registers on the peripheral bus.
module spi_target #(
  parameter logic [3:0] ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  spi_target_if.slave bus,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_en
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sckSync_q;
  logic [1:0]  csSync_q, mosiSync_q;
  logic [4:0]  config_q, config_d;
  logic [7:0]  txBuffer_q, txBuffer_d, rxBuffer_q, rxBuffer_d;
  logic        txEmpty_q, txEmpty_d, rxValid_q, rxValid_d, overrun_q, overrun_d;
  logic [7:0]  shiftOut_q, shiftOut_d, shiftIn_q, shiftIn_d;
  logic [2:0]  bitCount_q, bitCount_d;
  logic        modeCpha_q, modeCpha_d, modeCpol_q, modeCpol_d, modeMsb_q, modeMsb_d;

  logic        csActive, sckRise, sckFall, leadingEdge, trailingEdge;
  logic        sampleEdge, driveEdge, startFrame, fullByte, loadShift, selected;
  logic [7:0]  newByte, reloadByte;
  logic        devSel, readReq, writeReq, dataRdAccess;
  logic [11:0] localAddr;
  logic [31:0] readData;
  logic        unusedBus;

  assign csActive     = (csSync_q[1] == config_q[3]);
  assign sckRise      = sckSync_q[1] & ~sckSync_q[2];
  assign sckFall      = ~sckSync_q[1] & sckSync_q[2];
  assign leadingEdge  = modeCpol_q ? sckFall : sckRise;
  assign trailingEdge = modeCpol_q ? sckRise : sckFall;
  assign sampleEdge   = (state_q == SHIFT) && (modeCpha_q ? trailingEdge : leadingEdge);
  // bitCount==0 means the first bit is already on the pin; shifting now would skip it
  assign driveEdge    = (state_q == SHIFT) && (modeCpha_q ? leadingEdge : trailingEdge)
                        && (bitCount_q != 3'd0);
  assign startFrame   = (state_q == IDLE) && (state_d == SHIFT);
  assign fullByte     = sampleEdge && (bitCount_q == 3'd7);
  assign loadShift    = startFrame || fullByte;
  assign newByte      = modeMsb_q ? {shiftIn_q[6:0], mosiSync_q[1]} : {mosiSync_q[1], shiftIn_q[7:1]};
  assign reloadByte   = txEmpty_q ? 8'hFF : txBuffer_q;

  assign localAddr    = bus.peripheralBus_address[11:0];
  assign devSel       = bus.peripheralEnable && (bus.peripheralBus_address[15:12] == ID);
  assign readReq      = devSel && bus.peripheralBus_oe;
  assign writeReq     = devSel && bus.peripheralBus_we && bus.peripheralBus_byteSelect[0];
  assign dataRdAccess = readReq && (localAddr == 12'h004);
  assign unusedBus    = ^{bus.peripheralBus_byteSelect[3:1], bus.peripheralBus_dataWrite[31:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (config_q[4] && csActive) state_d = SHIFT;
      SHIFT:   if (!config_q[4] || !csActive) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    selected    = (state_q == SHIFT);
    spi_miso_en = selected && config_q[4];
    spi_miso    = spi_miso_en && (modeMsb_q ? shiftOut_q[7] : shiftOut_q[0]);
  end

  always_comb begin
    readData = 32'd0;
    case (localAddr)
      12'h000: readData = {27'd0, config_q};
      12'h004: readData = {24'd0, rxBuffer_q};
      12'h008: readData = {28'd0, selected, overrun_q, txEmpty_q, rxValid_q};
      default: readData = 32'd0;
    endcase
  end

  assign bus.requestOutput          = readReq;
  assign bus.peripheralBus_dataRead = readReq ? readData : ~32'd0;
  assign bus.peripheralBus_busy     = 1'b0;

  // Order matters: tx write beats reload's txEmpty, and byte completion beats read/clear.
  always_comb begin
    config_d   = config_q;
    txBuffer_d = txBuffer_q;
    txEmpty_d  = txEmpty_q;
    rxBuffer_d = rxBuffer_q;
    rxValid_d  = rxValid_q;
    overrun_d  = overrun_q;
    shiftOut_d = shiftOut_q;
    shiftIn_d  = shiftIn_q;
    bitCount_d = bitCount_q;
    modeCpha_d = modeCpha_q;
    modeCpol_d = modeCpol_q;
    modeMsb_d  = modeMsb_q;

    if (startFrame) begin
      modeCpha_d = config_q[0];
      modeCpol_d = config_q[1];
      modeMsb_d  = config_q[2];
    end
    if (sampleEdge) begin
      shiftIn_d  = newByte;
      bitCount_d = bitCount_q + 3'd1;
    end
    if (loadShift) begin
      shiftOut_d = reloadByte;
      txEmpty_d  = 1'b1;
      bitCount_d = 3'd0;
    end else if (driveEdge) begin
      shiftOut_d = modeMsb_q ? {shiftOut_q[6:0], 1'b1} : {1'b1, shiftOut_q[7:1]};
    end
    if (writeReq) begin
      case (localAddr)
        12'h000: config_d = bus.peripheralBus_dataWrite[4:0];
        12'h004: begin
          txBuffer_d = bus.peripheralBus_dataWrite[7:0];
          txEmpty_d  = 1'b0;
        end
        12'h008: if (bus.peripheralBus_dataWrite[2]) overrun_d = 1'b0;
        default: ;
      endcase
    end
    if (dataRdAccess) rxValid_d = 1'b0;
    if (fullByte) begin
      rxBuffer_d = newByte;
      rxValid_d  = 1'b1;
      if (rxValid_q && !dataRdAccess) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sckSync_q  <= 3'd0;
      csSync_q   <= 2'd0;
      mosiSync_q <= 2'd0;
      config_q   <= 5'h04;
      txBuffer_q <= 8'd0;
      txEmpty_q  <= 1'b1;
      rxBuffer_q <= 8'd0;
      rxValid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      shiftOut_q <= 8'd0;
      shiftIn_q  <= 8'd0;
      bitCount_q <= 3'd0;
      modeCpha_q <= 1'b0;
      modeCpol_q <= 1'b0;
      modeMsb_q  <= 1'b1;
    end else begin
      sckSync_q  <= {sckSync_q[1:0], spi_sck};
      csSync_q   <= {csSync_q[0], spi_cs};
      mosiSync_q <= {mosiSync_q[0], spi_mosi};
      config_q   <= config_d;
      txBuffer_q <= txBuffer_d;
      txEmpty_q  <= txEmpty_d;
      rxBuffer_q <= rxBuffer_d;
      rxValid_q  <= rxValid_d;
      overrun_q  <= overrun_d;
      shiftOut_q <= shiftOut_d;
      shiftIn_q  <= shiftIn_d;
      bitCount_q <= bitCount_d;
      modeCpha_q <= modeCpha_d;
      modeCpol_q <= modeCpol_d;
      modeMsb_q  <= modeMsb_d;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a bit-level SPI controller drives frames while a
// byte-level model predicts bus reads and MISO bytes.
`timescale 1ns/1ps
module tb_spi_target;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_en;

  spi_target_if bus();

  spi_target #(.ID(4'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_en(spi_miso_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t       busExpQ[$];
  logic [7:0] misoExpQ[$];
  logic [7:0] misoGotQ[$];
  int         nChecks = 0;
  int         nPass = 0;

  // Byte-level reference model
  logic [4:0] mCfg;
  logic [7:0] mTx, mRx;
  bit         mTxEmpty, mRxValid, mOverrun;
  bit         fCpol, fCpha, fMsb;
  logic [7:0] txBytes[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic void modelReset();
    mCfg = 5'h04; mTx = 8'h00; mRx = 8'h00;
    mTxEmpty = 1'b1; mRxValid = 1'b0; mOverrun = 1'b0;
  endfunction

  function automatic logic [7:0] take();
    logic [7:0] v;
    v = mTxEmpty ? 8'hFF : mTx;
    mTxEmpty = 1'b1;
    return v;
  endfunction

  function automatic void modelComplete(input logic [7:0] b);
    if (mRxValid) mOverrun = 1'b1;
    mRx = b;
    mRxValid = 1'b1;
  endfunction

  function automatic logic [31:0] modelStatus();
    return {28'd0, 1'b0, mOverrun, mTxEmpty, mRxValid};
  endfunction

  task automatic busWrite(input logic [15:0] addr, input logic [31:0] data);
    bus.peripheralEnable = 1'b1;
    bus.peripheralBus_we = 1'b1;
    bus.peripheralBus_address = addr;
    bus.peripheralBus_byteSelect = 4'h1;
    bus.peripheralBus_dataWrite = data;
    @(negedge clk);
    bus.peripheralBus_we = 1'b0;
    bus.peripheralEnable = 1'b0;
    case (addr[11:0])
      12'h000: mCfg = data[4:0];
      12'h004: begin mTx = data[7:0]; mTxEmpty = 1'b0; end
      12'h008: if (data[2]) mOverrun = 1'b0;
      default: ;
    endcase
  endtask

  task automatic busRead(input logic [15:0] addr, input string name);
    exp_t e;
    e.name = name;
    case (addr[11:0])
      12'h000: e.value = {27'd0, mCfg};
      12'h004: begin e.value = {24'd0, mRx}; mRxValid = 1'b0; end
      12'h008: e.value = modelStatus();
      default: e.value = 32'd0;
    endcase
    busExpQ.push_back(e);
    bus.peripheralEnable = 1'b1;
    bus.peripheralBus_oe = 1'b1;
    bus.peripheralBus_address = addr;
    @(negedge clk);
    bus.peripheralBus_oe = 1'b0;
    bus.peripheralEnable = 1'b0;
  endtask

  task automatic halfWait();
    repeat (6) @(negedge clk);
  endtask

  task automatic configure(input logic [3:0] c);
    busWrite(16'h0000, {27'd0, 1'b0, c});
    spi_cs = ~c[3];
    spi_sck = c[1];
    repeat (4) @(negedge clk);
    busWrite(16'h0000, {27'd0, 1'b1, c});
    repeat (4) @(negedge clk);
  endtask

  task automatic spiByte(input logic [7:0] d, input int nbits, input bit doRead, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = fMsb ? 7 - i : i;
      if (!fCpha) begin
        spi_mosi = d[idx];
        halfWait();
        spi_sck = ~fCpol;
        got[idx] = spi_miso;
        if (doRead && i == nbits - 1) begin
          repeat (2) @(negedge clk);
          busRead(16'h0004, "dataReadAtCompletion");
        end
        halfWait();
        spi_sck = fCpol;
      end else begin
        halfWait();
        spi_sck = ~fCpol;
        spi_mosi = d[idx];
        halfWait();
        spi_sck = fCpol;
        got[idx] = spi_miso;
        if (doRead && i == nbits - 1) begin
          repeat (2) @(negedge clk);
          busRead(16'h0004, "dataReadAtCompletion");
        end
      end
    end
  endtask

  task automatic spiFrame(input int nFull, input int partial, input bit doRead);
    logic [7:0] outByte, got;
    bit en, activeLvl;
    fCpha = mCfg[0]; fCpol = mCfg[1]; fMsb = mCfg[2];
    activeLvl = mCfg[3]; en = mCfg[4];
    outByte = 8'hFF;
    spi_sck = fCpol;
    spi_cs = activeLvl;
    if (en) outByte = take();
    repeat (6) @(negedge clk);
    check("misoEnable", {31'd0, spi_miso_en}, {31'd0, en});
    for (int j = 0; j < nFull; j++) begin
      if (en) misoExpQ.push_back(outByte);
      spiByte(txBytes[j], 8, doRead && (j == nFull - 1), got);
      if (en) begin
        misoGotQ.push_back(got);
        modelComplete(txBytes[j]);
        outByte = take();
      end
    end
    if (partial > 0) spiByte(txBytes[nFull], partial, 1'b0, got);
    repeat (6) @(negedge clk);
    spi_cs = ~activeLvl;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: compares every bus read the DUT presents and every finished MISO byte
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.requestOutput) begin
        if (busExpQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpectedRead: got 0x%08h, expected no read", bus.peripheralBus_dataRead);
        end else begin
          exp_t e;
          e = busExpQ.pop_front();
          check(e.name, bus.peripheralBus_dataRead, e.value);
        end
      end
      while (misoGotQ.size() > 0 && misoExpQ.size() > 0) begin
        logic [7:0] g, x;
        g = misoGotQ.pop_front();
        x = misoExpQ.pop_front();
        check("misoByte", {24'd0, g}, {24'd0, x});
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] got;
    bus.peripheralEnable = 1'b0;
    bus.peripheralBus_we = 1'b0;
    bus.peripheralBus_oe = 1'b0;
    bus.peripheralBus_address = 16'h0;
    bus.peripheralBus_byteSelect = 4'h0;
    bus.peripheralBus_dataWrite = 32'h0;
    modelReset();
    repeat (3) @(negedge clk);
    check("resetMiso", {31'd0, spi_miso}, 32'd0);
    check("resetMisoEn", {31'd0, spi_miso_en}, 32'd0);
    check("resetReqOut", {31'd0, bus.requestOutput}, 32'd0);
    check("resetDataRead", bus.peripheralBus_dataRead, 32'hFFFF_FFFF);
    check("resetBusy", {31'd0, bus.peripheralBus_busy}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    busRead(16'h0000, "resetConfig");
    busRead(16'h0008, "resetStatus");
    busRead(16'h0004, "resetData");

    // Mode 0, MSB first, tx 0xA5, rx 0x3C
    configure(4'h4);
    busWrite(16'h0004, 32'hA5);
    txBytes[0] = 8'h3C;
    spiFrame(1, 0, 1'b0);
    busRead(16'h0008, "mode0Status");
    busRead(16'h0004, "mode0Data");

    // Mode 3, LSB first, two bytes in one frame with empty tx
    configure(4'h3);
    txBytes[0] = 8'h81; txBytes[1] = 8'h7E;
    spiFrame(2, 0, 1'b0);
    busRead(16'h0008, "overrunStatus");
    busRead(16'h0004, "overrunData");
    busWrite(16'h0008, 32'h4);
    busRead(16'h0008, "overrunCleared");

    // Partial byte discarded, then a full byte
    configure(4'h4);
    txBytes[0] = 8'hF0;
    spiFrame(0, 5, 1'b0);
    busRead(16'h0008, "partialStatus");
    txBytes[0] = 8'h55;
    spiFrame(1, 0, 1'b0);
    busRead(16'h0004, "afterPartialData");

    // Disabled: CS ignored
    configure(4'h4);
    busWrite(16'h0000, 32'h04);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    busRead(16'h0008, "disabledStatusSelected");
    txBytes[0] = 8'h12;
    spiFrame(1, 0, 1'b0);
    busRead(16'h0008, "disabledStatus");

    // Data read on the completion cycle
    configure(4'h4);
    txBytes[0] = 8'h11;
    spiFrame(1, 0, 1'b0);
    txBytes[0] = 8'h99;
    spiFrame(1, 0, 1'b1);
    busRead(16'h0008, "simulReadStatus");
    busRead(16'h0004, "simulReadData");

    // Asynchronous reset mid-byte
    configure(4'h4);
    busWrite(16'h0004, 32'h5A);
    fCpha = 1'b0; fCpol = 1'b0; fMsb = 1'b1;
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    spiByte(8'hAA, 3, 1'b0, got);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midResetMiso", {31'd0, spi_miso}, 32'd0);
    check("midResetMisoEn", {31'd0, spi_miso_en}, 32'd0);
    check("midResetReqOut", {31'd0, bus.requestOutput}, 32'd0);
    check("midResetDataRead", bus.peripheralBus_dataRead, 32'hFFFF_FFFF);
    modelReset();
    @(negedge clk);
    busRead(16'h0000, "configInReset");
    spi_cs = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    busRead(16'h0008, "afterResetStatus");
    busRead(16'h0004, "afterResetData");

    // Randomised frames
    for (int it = 0; it < 20; it++) begin
      int nFull, partial;
      configure(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) busWrite(16'h0004, 32'($urandom_range(0, 255)));
      nFull = $urandom_range(1, 3);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 4; k++) txBytes[k] = 8'($urandom_range(0, 255));
      spiFrame(nFull, partial, $urandom_range(0, 3) == 0);
      busRead(16'h0008, "randStatus");
      if ($urandom_range(0, 1) == 1) busRead(16'h0004, "randData");
      if ($urandom_range(0, 1) == 1) busWrite(16'h0008, 32'h4);
      if ($urandom_range(0, 3) == 0) busRead(16'h0000, "randConfig");
    end

    repeat (10) @(negedge clk);
    if (busExpQ.size() != 0 || misoExpQ.size() != 0) begin
      nChecks++;
      $display("[TB] FAIL pendingExpectations: got %0d bus and %0d miso left, expected 0",
               busExpQ.size(), misoExpQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) peripheral, the responding end of the SPI link driven by the team's SPI controller peripherals. An external controller drives `spi_sck`, `spi_cs` and `spi_mosi`. The block shifts in one byte per 8 clocks into a receive holding register and shifts out a byte from a transmit holding register. It sits on the peripheral bus behind the standard device select (address[15:12] == ID) and exposes configuration, data and status registers.

## Interface
- `ID`, 4'h0, device select nibble compared against `peripheralBus_address[15:12]`
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `peripheralEnable`  in  1  peripheral bus enable
- `peripheralBus_we`  in  1  write strobe
- `peripheralBus_oe`  in  1  read strobe
- `peripheralBus_busy`  out  1  tied 0
- `peripheralBus_address`  in  16  byte address; [11:0] local
- `peripheralBus_byteSelect`  in  4  byte lanes
- `peripheralBus_dataRead`  out  32  read data; ~32'b0 when not requesting
- `peripheralBus_dataWrite`  in  32  write data
- `requestOutput`  out  1  high when a register of this device is being read
- `spi_sck`  in  1  SPI clock from controller, asynchronous
- `spi_cs`  in  1  chip select, polarity per config
- `spi_mosi`  in  1  serial data in
- `spi_miso`  out  1  serial data out
- `spi_miso_en`  out  1  output enable for `spi_miso` pad

## Operation
- Registers (local address, byteSelect[0] required for writes):
  - 0x000 config, default 0x04: b0 CPHA, b1 CPOL, b2 msbFirst, b3 activeHighCS, b4 enable.
  - 0x004 data, 8 bits. Write loads txBuffer and clears txEmpty. Read returns rxBuffer and clears rxValid on that clock edge.
  - 0x008 status, RO except b2: b0 rxValid, b1 txEmpty, b2 overrun (write 1 clears), b3 selected.
- `spi_sck`, `spi_cs` and `spi_mosi` each pass through a 2-flop synchronizer. A third flop on sck feeds the edge detector.
- Leading edge = rising if CPOL=0, else falling.
  - CPHA=0: sample on leading edge, shift out on trailing edge. The first bit is driven at CS assert.
  - CPHA=1: shift out on leading edge, sample on trailing edge.
- msbFirst=1 sends and receives bit7 first, otherwise bit0 first.
- Mode and bit order are latched at CS assert; config writes take effect at the next CS assert.
- State machine:
  - IDLE → SHIFT on synchronized CS assert with enable=1. On entry: load the shift register from txBuffer if !txEmpty, else 0xFF. Set txEmpty. bitCounter=0.
  - SHIFT: each sample edge shifts mosi in and increments bitCounter.
  - On the 8th sample: rxBuffer ← byte, rxValid=1 (overrun=1 if rxValid was already 1; rxBuffer overwritten). Reload the shift register as on entry, bitCounter=0. Stay in SHIFT.
  - SHIFT → IDLE on CS deassert. Any partial byte is discarded.
  - enable=0 forces IDLE.
- `spi_miso_en` = selected && enable. `spi_miso` = current output bit; 0 when not enabled.
- `spi_cs` ignored when enable=0.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_en`=0, `requestOutput`=0, `peripheralBus_dataRead`=~32'b0, `peripheralBus_busy`=0.
- Reset values (internal): rxBuffer=0, rxValid=0, txEmpty=1, overrun=0, config=0x04, state IDLE.
- Reset asserted mid-byte returns all of the above immediately.
- SPI pin edge to internal action: 3 clk cycles. `spi_sck` high and low phases must each be ≥ 4 clk cycles.
- rxValid is set 1 cycle after the 8th sample is taken. It is visible in status on the following read.
- Bus read is combinational in the same cycle: `requestOutput` and `dataRead` follow `peripheralEnable && oe && address` match.
- Bus writes land on the clk edge.
- Simultaneous byte completion and data-register read: the new byte wins. rxValid stays 1, overrun not set.
- Simultaneous txBuffer write and reload: the reload uses the pre-write state (0xFF if empty). The written byte stays in txBuffer and txEmpty=0.
- Data write while !txEmpty overwrites txBuffer.
- Simultaneous overrun set and overrun-clear write: set wins.

## Test plan
- Mode 0, msbFirst, txBuffer=0xA5, controller sends 0x3C → MISO carries 0xA5; rxBuffer=0x3C, rxValid=1, txEmpty=1.
- Mode 3, lsbFirst, two back-to-back bytes 0x81 then 0x7E, one CS, txBuffer empty → MISO sends 0xFF twice; second byte without an intervening read sets overrun=1 and rxBuffer=0x7E.
- CS deasserted after 5 bits of 0xF0 → rxValid stays 0, state IDLE; next full byte 0x55 is received correctly.
- enable=0 with CS asserted and 0x12 clocked → `spi_miso_en`=0, no rxValid; status b3=0.
- Read of data register in the same cycle as completion of 0x99 → dataRead returns the old byte; rxValid=1, rxBuffer=0x99, overrun=0.
- Async reset pulse mid-byte → all outputs at reset values within the same cycle; config reads back 0x04.
